// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 5x5 convolution chain.
//
// Holds the image geometry and pipeline latency used by both the
// convolution delay lines and the output collector, the collector FSM
// state type, the output FIFO entry layout and a small ReLU helper.
// No ports; import with "import conv_pkg::*;".
package conv_pkg;

  // Width of the saturated partial sum leaving the convolution chain
  localparam int O_SAT = 16;

  // Image geometry and kernel size (row pitch of the delay lines)
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;

  // Cycles from a pixel entering the chain to its psum at the collector
  localparam int LAT   = 5;

  // Width of the output row/column tags
  localparam int RC_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COLLECT,
    DRAIN
  } collector_state_t;

  typedef struct packed {
    logic signed [O_SAT-1:0] data;
    logic [RC_W-1:0]         row;
    logic [RC_W-1:0]         col;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Clamp negative values to zero when enabled, otherwise pass through
  function automatic logic signed [O_SAT-1:0] apply_relu(
    input logic signed [O_SAT-1:0] value,
    input logic                    enable
  );
    if (enable && (value < 0)) begin
      return '0;
    end
    return value;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage.
//
// The head entry is read straight from the storage registers, so it is
// visible the cycle after it is written and holds still until popped.
// A pop on a full FIFO frees its slot in the same cycle, letting a
// simultaneous push succeed. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset, empties the FIFO
//   i_push   write request (ignored when full and not popping)
//   i_data   write data
//   i_pop    read request (ignored when empty)
//   o_data   head entry
//   o_full   DEPTH entries stored
//   o_empty  no entries stored
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];

  // When full, the write slot is the head slot being popped this cycle,
  // so the overwrite lands exactly as the old head leaves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Output-side consumer of the streaming convolution chain.
//
// Tracks the raster position of the free-running psum stream, keeps only
// full-window results (col >= K-1 and row >= K-1), tags them with their
// output row/column, optionally applies ReLU and queues them in a FIFO
// that drains over a valid/ready handshake.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     pulse with the first pixel of a frame entering the chain
//   i_psum      convolution output stream (signed)
//   o_data      result at FIFO head (signed)
//   o_row       output row of o_data, 0..IMG_H-K
//   o_col       output column of o_data, 0..IMG_W-K
//   o_valid     FIFO head valid
//   i_ready     downstream accepts; transfer when o_valid && i_ready
//   o_busy      frame in progress
//   o_done      one-cycle pulse once a frame is fully drained
//   o_overflow  sticky: a valid window was dropped on a full FIFO
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit RELU       = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic signed [O_SAT-1:0] i_psum,
  output logic signed [O_SAT-1:0] o_data,
  output logic [RC_W-1:0]         o_row,
  output logic [RC_W-1:0]         o_col,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);

  collector_state_t r_state;
  collector_state_t w_next_state;

  logic [CNT_W-1:0] r_lat_cnt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_overflow;

  logic        w_sample;
  logic        w_last_pix;
  logic        w_window;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  fifo_entry_t w_wr_entry;
  fifo_entry_t w_head;
  logic [ENTRY_W-1:0] w_fifo_rd;

  // With zero latency the start cycle itself already carries pixel (0,0)
  assign w_sample   = (r_state == COLLECT) ||
                      ((r_state == IDLE) && i_start && (LAT == 0));
  assign w_last_pix = w_sample && (r_row == ROW_W'(IMG_H - 1)) &&
                      (r_col == COL_W'(IMG_W - 1));
  assign w_window   = w_sample && (r_col >= COL_W'(K - 1)) &&
                      (r_row >= ROW_W'(K - 1));

  assign w_wr_entry.data = apply_relu(i_psum, RELU);
  assign w_wr_entry.row  = RC_W'(r_row - ROW_W'(K - 1));
  assign w_wr_entry.col  = RC_W'(r_col - COL_W'(K - 1));

  assign w_head     = fifo_entry_t'(w_fifo_rd);
  assign o_data     = w_head.data;
  assign o_row      = w_head.row;
  assign o_col      = w_head.col;
  assign o_valid    = !w_fifo_empty;
  assign w_pop      = o_valid && i_ready;
  assign o_busy     = (r_state != IDLE);
  assign o_overflow = r_overflow;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_window),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FILL ends when the countdown reaches zero, so COLLECT starts exactly
  // LAT cycles after i_start; LAT of 0 or 1 skips FILL entirely.
  always_comb begin
    w_next_state = r_state;
    o_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = (LAT <= 1) ? COLLECT : FILL;
        end
      end
      FILL: begin
        if (r_lat_cnt == CNT_W'(1)) begin
          w_next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (w_last_pix) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fifo_empty) begin
          o_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_cnt <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_lat_cnt <= CNT_W'(LAT - 1);
    end else if (r_state == FILL) begin
      r_lat_cnt <= r_lat_cnt - CNT_W'(1);
    end
  end

  // Raster position of the psum on i_psum; wraps back to (0,0) after the
  // last pixel so the next frame starts clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_sample) begin
      if (r_col == COL_W'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // A pop in the same cycle frees a slot, so only a full FIFO that is not
  // being read drops the window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_window && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
